uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares the single UART byte transmitter between two 32-bit word producers, the CPU and the FPGA fabric. It arbitrates word requests round-robin and serializes each granted word into a tagged byte frame. The frame is an optional header byte identifying the source, followed by DATA_W/8 data bytes, MSB first. It sits between the requesters and the uart_comm byte-transmit interface.

Parameters:
DATA_W, 32, requester word width; must be a multiple of 8 and at least 8
HDR_EN, 1, 1 = prepend a header byte to each frame; 0 = data bytes only
HDR_BASE, 8'hA0, header byte value; bit 0 is replaced by the source ID (0 = CPU, 1 = FPGA)

Ports:
clk  in  1  system clock; all state changes on the rising edge
reset  in  1  asynchronous, active-low reset
cpu_valid  in  1  CPU word request
cpu_data  in  DATA_W  CPU word
cpu_ready  out  1  CPU word accepted this cycle (word taken when cpu_valid & cpu_ready)
fpga_valid  in  1  FPGA word request
fpga_data  in  DATA_W  FPGA word
fpga_ready  out  1  FPGA word accepted this cycle
tx_valid  out  1  byte available to the UART transmitter
tx_data  out  8  byte to the UART transmitter
tx_ready  in  1  UART accepts the byte (transfer when tx_valid & tx_ready)
busy  out  1  frame in progress (state != IDLE)
cur_src  out  1  source of the current or last frame (0 = CPU, 1 = FPGA)

Behaviour:
- Reset (reset = 0, takes effect immediately, no clock needed):
  - state = IDLE; tx_valid = 0, tx_data = 0, busy = 0, cur_src = 0.
  - Byte counter = 0; round-robin pointer prio = CPU.
  - cpu_ready and fpga_ready read 0 while reset is asserted.
  - A frame in progress is aborted: no further bytes, and the partial frame is not resumed.
- States: IDLE, HDR, DATA.
- IDLE arbitration (combinational ready):
  - Only one valid: that requester gets ready = 1.
  - Both valid: the requester indicated by prio gets ready = 1; the other gets 0.
  - Never both ready in the same cycle; ready = 0 in HDR and DATA.
- On accept (valid & ready, rising edge):
  - Latch the word into the shift register and set cur_src.
  - Set prio to the other requester.
  - Next state = HDR if HDR_EN, else DATA; byte counter = 0.
- HDR:
  - tx_valid = 1, tx_data = {HDR_BASE[7:1], cur_src}.
  - On tx_ready go to DATA.
- DATA:
  - tx_valid = 1, tx_data = word byte at index (DATA_W/8 - 1 - cnt), i.e. MSB first.
  - On tx_ready: if cnt == DATA_W/8 - 1 go to IDLE, else cnt + 1.
- tx_data and tx_valid are registered.
  - Once tx_valid is raised, tx_valid and tx_data hold stable until tx_ready is sampled high. Backpressure of any length is tolerated.
  - tx_valid = 0 in IDLE.
- Latency and throughput with tx_ready held at 1:
  - Accept in cycle N, header in N+1, data bytes in N+2..N+5, IDLE in N+6.
  - The next accept can occur in N+6, giving 6 cycles per frame with HDR_EN = 1 and 5 cycles with HDR_EN = 0.
- Latched-word rules:
  - Requester data changes after accept do not affect the frame.
  - A requester deasserting valid without a handshake is legal; no word is accepted.
- prio changes only on accept. A lone requester is granted back-to-back; fairness applies only under contention.
- busy = 1 in HDR and DATA.

Test Plan:
- Reset, then cpu_valid = 1, cpu_data = 32'h11223344, tx_ready = 1 -> cpu_ready pulses one cycle; tx bytes A0, 11, 22, 33, 44 on consecutive cycles; busy high for 5 cycles.
- cpu_valid and fpga_valid held together (CPU 32'hDEADBEEF, FPGA 32'h01020304) -> frames alternate in order CPU, FPGA, CPU; FPGA header is A1; each frame starts 6 cycles after the previous one.
- FPGA frame with tx_ready toggled 1-0-0-1 pseudo-randomly -> tx_data stable whenever tx_valid & !tx_ready; the received stream is exactly A1, 01, 02, 03, 04.
- HDR_EN = 0, fpga word 32'hCAFEF00D -> bytes CA, FE, F0, 0D only; next accept 5 cycles after the previous one.
- reset asserted after the second data byte of a CPU frame -> tx_valid = 0 and busy = 0 immediately. After release with both requesters valid, CPU is granted first (prio reset to CPU) and its frame starts with A0.
- cpu_data changed on the cycle after accept -> transmitted bytes match the originally accepted word.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART byte transmitter between CPU and FPGA word producers
module uart_tx_arbiter #(
  parameter int          DATA_W   = 32,
  parameter bit          HDR_EN   = 1'b1,
  parameter logic [7:0]  HDR_BASE = 8'hA0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_valid,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              cpu_ready,
  input  logic              fpga_valid,
  input  logic [DATA_W-1:0] fpga_data,
  output logic              fpga_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              busy,
  output logic              cur_src
);
  localparam int NB = DATA_W / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HDR  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic              prio;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] word;
  logic              take;
  logic              sent;
  logic              last;
  // Grant in IDLE only; contention resolved by prio, and nothing is granted while reset is held
  always_comb begin
    cpu_ready  = reset && (state == IDLE) && cpu_valid && (!fpga_valid || !prio);
    fpga_ready = reset && (state == IDLE) && fpga_valid && (!cpu_valid || prio);
    take       = (cpu_valid && cpu_ready) || (fpga_valid && fpga_ready);
    word       = fpga_ready ? fpga_data : cpu_data;
    shifted    = shreg << 8;
    sent       = tx_valid && tx_ready;
    last       = cnt == CW'(NB - 1);
    busy       = state != IDLE;
  end
  // Frame sequencer: the next byte is loaded into the tx register only when the current one is taken
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      prio     <= 1'b0;
      shreg    <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      cur_src  <= 1'b0;
    end else if (state == IDLE) begin
      if (take) begin
        shreg    <= word;
        cur_src  <= fpga_ready;
        prio     <= !fpga_ready;
        cnt      <= '0;
        tx_valid <= 1'b1;
        state    <= HDR_EN ? HDR : DATA;
        tx_data  <= HDR_EN ? {HDR_BASE[7:1], fpga_ready} : word[DATA_W-1 -: 8];
      end
    end else if (sent) begin
      if (state == HDR) begin
        state   <= DATA;
        tx_data <= shreg[DATA_W-1 -: 8];
      end else if (last) begin
        state    <= IDLE;
        tx_valid <= 1'b0;
        tx_data  <= '0;
      end else begin
        cnt     <= cnt + 1'b1;
        shreg   <= shifted;
        tx_data <= shifted[DATA_W-1 -: 8];
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: table-driven and directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_valid = 1'b0, fpga_valid = 1'b0, tx_ready = 1'b0;
  logic [31:0] cpu_data = '0, fpga_data = '0;
  logic        cpu_ready, fpga_ready, tx_valid, busy, cur_src;
  logic [7:0]  tx_data;
  logic        b_cpu_valid = 1'b0, b_fpga_valid = 1'b0, b_tx_ready = 1'b1;
  logic [31:0] b_cpu_data = '0, b_fpga_data = '0;
  logic        b_cpu_ready, b_fpga_ready, b_tx_valid, b_busy, b_cur_src;
  logic [7:0]  b_tx_data;
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  rx[$];

  typedef struct {
    logic        rst, cv;
    logic [31:0] cd;
    logic        fv;
    logic [31:0] fd;
    logic        tr, ecr, efr, etv;
    logic [7:0]  etd;
    logic        eb, es;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.DATA_W(32), .HDR_EN(1'b1), .HDR_BASE(8'hA0)) dut (
    .clk(clk), .reset(reset),
    .cpu_valid(cpu_valid), .cpu_data(cpu_data), .cpu_ready(cpu_ready),
    .fpga_valid(fpga_valid), .fpga_data(fpga_data), .fpga_ready(fpga_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .busy(busy), .cur_src(cur_src)
  );

  uart_tx_arbiter #(.DATA_W(32), .HDR_EN(1'b0), .HDR_BASE(8'hA0)) dut_nohdr (
    .clk(clk), .reset(reset),
    .cpu_valid(b_cpu_valid), .cpu_data(b_cpu_data), .cpu_ready(b_cpu_ready),
    .fpga_valid(b_fpga_valid), .fpga_data(b_fpga_data), .fpga_ready(b_fpga_ready),
    .tx_valid(b_tx_valid), .tx_data(b_tx_data), .tx_ready(b_tx_ready),
    .busy(b_busy), .cur_src(b_cur_src)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic cv, input logic [31:0] cd, input logic fv,
                     input logic [31:0] fd, input logic ecr, input logic efr, input logic etv,
                     input logic [7:0] etd, input logic eb, input logic es);
    vec_t v;
    v.rst = rst; v.cv = cv; v.cd = cd; v.fv = fv; v.fd = fd; v.tr = 1'b1;
    v.ecr = ecr; v.efr = efr; v.etv = etv; v.etd = etd; v.eb = eb; v.es = es;
    tbl.push_back(v);
  endtask

  task automatic run_rx(input bit use_pat, input int maxc);
    logic [15:0] pat = 16'b1001_1010_0110_0101;
    logic        pv = 1'b0, pr = 1'b0;
    logic [7:0]  pd = '0;
    rx.delete();
    for (int c = 0; c < maxc && rx.size() < 5; c++) begin
      @(negedge clk);
      tx_ready = use_pat ? pat[15 - (c % 16)] : 1'b1;
      #1;
      if (pv && !pr) begin
        chk("hold_valid", tx_valid, 1'b1);
        chk("hold_data", tx_data, pd);
      end
      if (tx_valid && tx_ready) rx.push_back(tx_data);
      pv = tx_valid; pr = tx_ready; pd = tx_data;
    end
  endtask

  task automatic cmp_rx(input string nm, input logic [7:0] e[5]);
    chk({nm, "_count"}, rx.size(), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("%s_byte%0d", nm, i), (i < rx.size()) ? {24'h0, rx[i]} : 32'hFFFF_FFFF, e[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] f1[5], f2[5], f3[5];
    logic [7:0] exp_bp[5], exp_keep[5], exp_b[4];
    int acc[$];
    logic [7:0] bq[$];
    f1 = '{8'hA0, 8'h11, 8'h22, 8'h33, 8'h44};
    f2 = '{8'hA0, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    f3 = '{8'hA1, 8'h01, 8'h02, 8'h03, 8'h04};
    // single CPU word
    add(1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    add(0, 1, 32'h11223344, 0, 0, 1, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 32'h11223344, 0, 0, 0, 0, 1, f1[i], 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    // contention: CPU, FPGA, CPU
    add(1, 1, 32'hDEADBEEF, 1, 32'h01020304, 0, 0, 0, 8'h00, 0, 0);
    add(0, 1, 32'hDEADBEEF, 1, 32'h01020304, 1, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 1, 32'hDEADBEEF, 1, 32'h01020304, 0, 0, 1, f2[i], 1, 0);
    add(0, 1, 32'hDEADBEEF, 1, 32'h01020304, 0, 1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 1, 32'hDEADBEEF, 1, 32'h01020304, 0, 0, 1, f3[i], 1, 1);
    add(0, 1, 32'hDEADBEEF, 1, 32'h01020304, 1, 0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 5; i++) add(0, 0, 32'hDEADBEEF, 0, 32'h01020304, 0, 0, 1, f2[i], 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      reset = !tbl[i].rst;
      cpu_valid = tbl[i].cv; cpu_data = tbl[i].cd;
      fpga_valid = tbl[i].fv; fpga_data = tbl[i].fd;
      tx_ready = tbl[i].tr;
      #1;
      chk($sformatf("v%0d_cpu_ready", i), cpu_ready, tbl[i].ecr);
      chk($sformatf("v%0d_fpga_ready", i), fpga_ready, tbl[i].efr);
      chk($sformatf("v%0d_tx_valid", i), tx_valid, tbl[i].etv);
      if (tbl[i].etv) chk($sformatf("v%0d_tx_data", i), tx_data, tbl[i].etd);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].eb);
      chk($sformatf("v%0d_cur_src", i), cur_src, tbl[i].es);
    end

    // FPGA frame under pseudo-random backpressure
    @(negedge clk);
    fpga_valid = 1'b1; fpga_data = 32'h01020304; cpu_valid = 1'b0; tx_ready = 1'b1;
    #1;
    chk("bp_fpga_ready", fpga_ready, 1'b1);
    @(posedge clk); #1;
    fpga_valid = 1'b0;
    run_rx(1'b1, 100);
    exp_bp = '{8'hA1, 8'h01, 8'h02, 8'h03, 8'h04};
    cmp_rx("bp", exp_bp);

    // reset in the middle of a CPU frame, then prio must be back on CPU
    @(negedge clk);
    cpu_valid = 1'b1; cpu_data = 32'h11223344; tx_ready = 1'b1;
    #1;
    chk("mid_accept", cpu_ready, 1'b1);
    @(negedge clk); cpu_valid = 1'b0; #1; chk("mid_hdr", tx_data, 8'hA0);
    @(negedge clk); #1; chk("mid_d0", tx_data, 8'h11);
    @(negedge clk); #1; chk("mid_d1", tx_data, 8'h22);
    @(negedge clk);
    reset = 1'b0;
    cpu_valid = 1'b1; cpu_data = 32'hDEADBEEF; fpga_valid = 1'b1; fpga_data = 32'h01020304;
    #1;
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cpu_ready", cpu_ready, 1'b0);
    chk("rst_fpga_ready", fpga_ready, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("post_rst_cpu_ready", cpu_ready, 1'b1);
    chk("post_rst_fpga_ready", fpga_ready, 1'b0);
    @(negedge clk);
    cpu_valid = 1'b0; fpga_valid = 1'b0;
    #1;
    chk("post_rst_hdr", tx_data, 8'hA0);
    chk("post_rst_src", cur_src, 1'b0);
    repeat (6) @(negedge clk);

    // requester data changes right after accept
    #1;
    cpu_valid = 1'b1; cpu_data = 32'hAABBCCDD;
    #1;
    chk("keep_accept", cpu_ready, 1'b1);
    @(posedge clk); #1;
    cpu_valid = 1'b0; cpu_data = 32'h55667788;
    run_rx(1'b0, 20);
    exp_keep = '{8'hA0, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    cmp_rx("keep", exp_keep);

    // no-header instance: FPGA word held valid
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      b_fpga_valid = 1'b1; b_fpga_data = 32'hCAFEF00D; b_tx_ready = 1'b1;
      #1;
      if (b_fpga_ready) acc.push_back(c);
      if (b_tx_valid && b_tx_ready) bq.push_back(b_tx_data);
    end
    b_fpga_valid = 1'b0;
    exp_b = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
    for (int i = 0; i < 4; i++)
      chk($sformatf("nohdr_byte%0d", i), (i < bq.size()) ? {24'h0, bq[i]} : 32'hFFFF_FFFF, exp_b[i]);
    chk("nohdr_accepts", acc.size() >= 2, 1'b1);
    chk("nohdr_spacing", (acc.size() >= 2) ? acc[1] - acc[0] : -1, 5);
    chk("nohdr_src", b_cur_src, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
